// File: rtl/booth_seq_mul.sv
// booth_seq_mul: sequential signed radix-2 Booth multiplier with a start/done handshake
module booth_seq_mul #(
  parameter int DATA_SIZE = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     start_i,
  input  logic [DATA_SIZE-1:0]     A_i,
  input  logic [DATA_SIZE-1:0]     B_i,
  output logic                     busy_o,
  output logic                     done_o,
  output logic [2*DATA_SIZE-1:0]   P_o
);
  localparam int CW = $clog2(DATA_SIZE) + 1;
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t                r_state, w_next;
  logic [DATA_SIZE:0]    r_m, r_acc, w_sum;
  logic [DATA_SIZE-1:0]  r_q;
  logic                  r_q1, r_busy, r_done, w_load, w_last;
  logic [CW-1:0]         r_cnt;
  logic [2*DATA_SIZE-1:0] r_p;
  always_comb begin
    w_sum  = ({r_q[0], r_q1} == 2'b01) ? r_acc + r_m :
             ({r_q[0], r_q1} == 2'b10) ? r_acc - r_m : r_acc;
    w_last = r_cnt == CW'(DATA_SIZE - 1);
    w_load = start_i && (r_state != CALC);
    w_next = (r_state == CALC) ? (w_last ? DONE : CALC) : (start_i ? CALC : IDLE);
  end
  // ACC is one bit wider than the operands so ACC-M cannot overflow for A = -2^(N-1)
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= IDLE;
      r_m     <= '0;
      r_acc   <= '0;
      r_q     <= '0;
      r_q1    <= 1'b0;
      r_cnt   <= '0;
      r_p     <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_busy  <= w_next == CALC;
      r_done  <= w_next == DONE;
      if (w_load) begin
        r_m   <= {A_i[DATA_SIZE-1], A_i};
        r_acc <= '0;
        r_q   <= B_i;
        r_q1  <= 1'b0;
        r_cnt <= '0;
      end else if (r_state == CALC) begin
        r_acc <= {w_sum[DATA_SIZE], w_sum[DATA_SIZE:1]};
        r_q   <= {w_sum[0], r_q[DATA_SIZE-1:1]};
        r_q1  <= r_q[0];
        r_cnt <= r_cnt + 1'b1;
        if (w_last) r_p <= {w_sum, r_q[DATA_SIZE-1:1]};
      end
    end
  end
  assign busy_o = r_busy;
  assign done_o = r_done;
  assign P_o    = r_p;
endmodule
